// File: rtl/obc_shift_acc_if.sv
// Conversion request, partial-product stream and result bus for one OBC lane.
interface obc_shift_acc_if #(
  parameter int PP_W  = 32,
  parameter int OUT_W = 32
);
  logic             start;
  logic [PP_W-1:0]  offset;
  logic [PP_W-1:0]  pp;
  logic             pp_valid;
  logic             pp_ready;
  logic             busy;
  logic [OUT_W-1:0] result;
  logic             result_valid;
  logic             overflow;

  modport master (
    output start, offset, pp, pp_valid,
    input  pp_ready, busy, result, result_valid, overflow
  );

  modport slave (
    input  start, offset, pp, pp_valid,
    output pp_ready, busy, result, result_valid, overflow
  );
endinterface

// File: rtl/obc_shift_acc.sv
// MSB-first OBC accumulate-and-shift: result_valid one edge after the FINAL state,
// pp accepted only in ACCUM (pp_valid gaps stall the accumulation).
module obc_shift_acc #(
  parameter int PP_W       = 32,
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 32,
  parameter int NBITS      = 16,
  parameter int SIGNED_MSB = 1,
  parameter int SAT        = 1
) (
  input  logic             clk,
  input  logic             rst,
  obc_shift_acc_if.slave   bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam int CNT_W = $clog2(NBITS);
  localparam int XW    = ACC_W - OUT_W + 1;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             overflow_q, overflow_d;

  logic [ACC_W-1:0] pp_ext;
  logic [ACC_W-1:0] sum;
  logic [XW-1:0]    sum_hi;
  logic             sum_ovf;

  assign pp_ext = {{(ACC_W-PP_W){bus.pp[PP_W-1]}}, bus.pp};
  assign sum    = acc_q + off_q;
  // Sum fits OUT_W only if every bit from OUT_W-1 upward equals the sign.
  assign sum_hi  = sum[ACC_W-1:OUT_W-1];
  assign sum_ovf = !((&sum_hi) || !(|sum_hi));

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    off_d          = off_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    overflow_d     = overflow_q;
    result_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          off_d   = {{(ACC_W-PP_W){bus.offset[PP_W-1]}}, bus.offset};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.pp_valid) begin
          if (cnt_q == '0)
            acc_d = (SIGNED_MSB != 0) ? -pp_ext : pp_ext;
          else
            acc_d = {acc_q[ACC_W-2:0], 1'b0} + pp_ext;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NBITS-1))
            state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        result_valid_d = 1'b1;
        overflow_d     = sum_ovf;
        if ((SAT != 0) && sum_ovf)
          result_d = sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        else
          result_d = sum[OUT_W-1:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      acc_q          <= '0;
      off_q          <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      off_q          <= off_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  assign bus.pp_ready     = (state_q == S_ACCUM);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_obc_shift_acc.sv
// Directed checks of obc_shift_acc: four parameterisations driven from two shared stimulus sets.
module tb_obc_shift_acc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_start, a_pp_valid;
  logic [31:0] a_offset, a_pp;
  logic        b_start, b_pp_valid;
  logic [7:0]  b_offset, b_pp;

  obc_shift_acc_if #(.PP_W(32), .OUT_W(32)) if_a ();
  obc_shift_acc_if #(.PP_W(32), .OUT_W(32)) if_d ();
  obc_shift_acc_if #(.PP_W(8),  .OUT_W(8))  if_b ();
  obc_shift_acc_if #(.PP_W(8),  .OUT_W(8))  if_c ();

  assign if_a.start = a_start;  assign if_a.offset = a_offset;
  assign if_a.pp    = a_pp;     assign if_a.pp_valid = a_pp_valid;
  assign if_d.start = a_start;  assign if_d.offset = a_offset;
  assign if_d.pp    = a_pp;     assign if_d.pp_valid = a_pp_valid;
  assign if_b.start = b_start;  assign if_b.offset = b_offset;
  assign if_b.pp    = b_pp;     assign if_b.pp_valid = b_pp_valid;
  assign if_c.start = b_start;  assign if_c.offset = b_offset;
  assign if_c.pp    = b_pp;     assign if_c.pp_valid = b_pp_valid;

  obc_shift_acc #(.PP_W(32), .ACC_W(40), .OUT_W(32), .NBITS(4), .SIGNED_MSB(1), .SAT(1))
    u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  obc_shift_acc #(.PP_W(32), .ACC_W(40), .OUT_W(32), .NBITS(4), .SIGNED_MSB(0), .SAT(1))
    u_d (.clk(clk), .rst(rst), .bus(if_d.slave));
  obc_shift_acc #(.PP_W(8), .ACC_W(16), .OUT_W(8), .NBITS(2), .SIGNED_MSB(1), .SAT(1))
    u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  obc_shift_acc #(.PP_W(8), .ACC_W(16), .OUT_W(8), .NBITS(2), .SIGNED_MSB(1), .SAT(0))
    u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  typedef struct packed {
    logic [31:0]       off;
    logic [3:0][31:0]  pp;
    logic [31:0]       ea;
    logic              oa;
    logic [31:0]       ed;
    logic              od;
  } vec_a_t;

  typedef struct packed {
    logic [31:0] off;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] eb;
    logic        ob;
    logic [31:0] ec;
    logic        oc;
  } vec_b_t;

  int n_cmp = 0;
  int n_err = 0;
  longint last_a = 0, last_d = 0, last_b = 0, last_c = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_a_t mka(input int off, input int p0, input int p1, input int p2,
                                 input int p3, input int ea, input bit oa, input int ed,
                                 input bit od);
    vec_a_t v;
    v.off = off; v.pp[0] = p0; v.pp[1] = p1; v.pp[2] = p2; v.pp[3] = p3;
    v.ea = ea; v.oa = oa; v.ed = ed; v.od = od;
    return v;
  endfunction

  function automatic vec_b_t mkb(input int off, input int p0, input int p1, input int eb,
                                 input bit ob, input int ec, input bit oc);
    vec_b_t v;
    v.off = off; v.p0 = p0; v.p1 = p1; v.eb = eb; v.ob = ob; v.ec = ec; v.oc = oc;
    return v;
  endfunction

  // One 4-plane conversion on u_a/u_d; gaps follow planes 0 and 1, junk drives start meanwhile.
  task automatic conv_a(input vec_a_t v, input int g0, input int g1, input bit junk);
    int g;
    a_start = 1'b1; a_offset = v.off; a_pp_valid = 1'b0;
    step();
    a_start = 1'b0;
    chk("a_rv_after_start", if_a.result_valid, 0);
    chk("a_held_result", $signed(if_a.result), last_a);
    chk("d_held_result", $signed(if_d.result), last_d);
    for (int i = 0; i < 4; i++) begin
      chk("a_pp_ready_accum", if_a.pp_ready, 1);
      chk("a_busy_accum", if_a.busy, 1);
      a_pp = v.pp[i]; a_pp_valid = 1'b1;
      step();
      a_pp_valid = 1'b0;
      a_pp = 32'hDEAD_BEEF;
      g = (i == 0) ? g0 : ((i == 1) ? g1 : 0);
      for (int k = 0; k < g; k++) begin
        if (junk) begin a_start = 1'b1; a_offset = 32'd12345; end
        step();
        a_start = 1'b0;
        chk("a_early_rv", if_a.result_valid, 0);
        chk("d_early_rv", if_d.result_valid, 0);
      end
    end
    chk("a_final_rv", if_a.result_valid, 0);
    chk("a_final_busy", if_a.busy, 1);
    chk("a_final_pp_ready", if_a.pp_ready, 0);
    if (junk) begin a_start = 1'b1; a_offset = 32'd12345; end
    step();
    a_start = 1'b0;
    chk("a_rv", if_a.result_valid, 1);
    chk("a_busy_at_rv", if_a.busy, 0);
    chk("a_result", $signed(if_a.result), $signed(v.ea));
    chk("a_overflow", if_a.overflow, v.oa);
    chk("d_rv", if_d.result_valid, 1);
    chk("d_result", $signed(if_d.result), $signed(v.ed));
    chk("d_overflow", if_d.overflow, v.od);
    last_a = $signed(v.ea);
    last_d = $signed(v.ed);
  endtask

  task automatic conv_b(input vec_b_t v);
    b_start = 1'b1; b_offset = v.off[7:0]; b_pp_valid = 1'b0;
    step();
    b_start = 1'b0;
    chk("b_held_result", $signed(if_b.result), last_b);
    chk("c_held_result", $signed(if_c.result), last_c);
    b_pp = v.p0[7:0]; b_pp_valid = 1'b1;
    step();
    b_pp = v.p1[7:0];
    step();
    b_pp_valid = 1'b0;
    chk("b_final_rv", if_b.result_valid, 0);
    step();
    chk("b_rv", if_b.result_valid, 1);
    chk("b_result", $signed(if_b.result), $signed(v.eb));
    chk("b_overflow", if_b.overflow, v.ob);
    chk("c_rv", if_c.result_valid, 1);
    chk("c_result", $signed(if_c.result), $signed(v.ec));
    chk("c_overflow", if_c.overflow, v.oc);
    last_b = $signed(v.eb);
    last_c = $signed(v.ec);
  endtask

  vec_a_t ta[9];
  vec_b_t tb_v[7];

  initial begin
    ta[0] = mka(5, 3, 1, 0, 2, -13, 0, 35, 0);
    ta[1] = mka(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ta[2] = mka(0, -1, 0, 0, 0, 8, 0, -8, 0);
    ta[3] = mka(0, 32'h8000_0000, 0, 0, 0, 32'h7FFF_FFFF, 1, 32'h8000_0000, 1);
    ta[4] = mka(0, 32'h7FFF_FFFF, 0, 0, 0, 32'h8000_0000, 1, 32'h7FFF_FFFF, 1);
    ta[5] = mka(32'h7FFF_FFFF, 0, 0, 0, 0, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0);
    ta[6] = mka(32'h8000_0000, 0, 0, 0, 0, 32'h8000_0000, 0, 32'h8000_0000, 0);
    ta[7] = mka(-7, 10, -3, 4, 1, -90, 0, 70, 0);
    ta[8] = mka(32'h7FFF_FFFF, 0, 0, 0, 1, 32'h7FFF_FFFF, 1, 32'h7FFF_FFFF, 1);

    tb_v[0] = mkb(100, 0, 100, 127, 1, -56, 1);
    tb_v[1] = mkb(-100, 100, 0, -128, 1, -44, 1);
    tb_v[2] = mkb(10, 3, 5, 9, 0, 9, 0);
    tb_v[3] = mkb(127, 0, 0, 127, 0, 127, 0);
    tb_v[4] = mkb(-128, 0, 0, -128, 0, -128, 0);
    tb_v[5] = mkb(127, 0, 1, 127, 1, -128, 1);
    tb_v[6] = mkb(-128, 1, 0, -128, 1, 126, 1);

    rst = 1'b1;
    a_start = 1'b0; a_offset = '0; a_pp = '0; a_pp_valid = 1'b0;
    b_start = 1'b0; b_offset = '0; b_pp = '0; b_pp_valid = 1'b0;
    step();
    step();
    chk("rst_a_busy", if_a.busy, 0);
    chk("rst_a_pp_ready", if_a.pp_ready, 0);
    chk("rst_a_result", if_a.result, 0);
    chk("rst_a_rv", if_a.result_valid, 0);
    chk("rst_a_ovf", if_a.overflow, 0);
    chk("rst_b_result", if_b.result, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) conv_a(ta[i], 0, 0, 1'b0);
    step();
    chk("a_rv_single_pulse", if_a.result_valid, 0);
    for (int i = 0; i < 7; i++) conv_b(tb_v[i]);

    // Stalls of 1 and 3 cycles between planes.
    conv_a(ta[0], 1, 3, 1'b0);

    // pp_valid in IDLE ignored; start during ACCUM/FINAL ignored.
    step();
    a_pp = 32'd77; a_pp_valid = 1'b1;
    step();
    chk("idle_pp_busy", if_a.busy, 0);
    chk("idle_pp_ready", if_a.pp_ready, 0);
    step();
    chk("idle_pp_busy2", if_a.busy, 0);
    a_pp_valid = 1'b0;
    conv_a(ta[7], 1, 1, 1'b1);

    // Back-to-back: start asserted in the result_valid cycle.
    conv_a(mka(0, 1, 1, 1, 1, -1, 0, 15, 0), 0, 0, 1'b0);
    conv_a(mka(0, 1, 1, 1, 1, -1, 0, 15, 0), 0, 0, 1'b0);

    // Asynchronous reset after two of four planes.
    step();
    a_start = 1'b1; a_offset = 32'd5;
    step();
    a_start = 1'b0;
    a_pp = 32'd3; a_pp_valid = 1'b1;
    step();
    a_pp = 32'd1;
    step();
    a_pp = 32'd0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_a_busy", if_a.busy, 0);
    chk("arst_a_pp_ready", if_a.pp_ready, 0);
    chk("arst_a_result", if_a.result, 0);
    chk("arst_a_rv", if_a.result_valid, 0);
    chk("arst_a_ovf", if_a.overflow, 0);
    chk("arst_d_result", if_d.result, 0);
    chk("arst_b_result", if_b.result, 0);
    a_pp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_rst_no_rv", if_a.result_valid, 0);
      chk("post_rst_idle", if_a.busy, 0);
    end
    last_a = 0; last_d = 0;
    conv_a(ta[0], 0, 0, 1'b0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
